// File: rtl/bank_port_arbiter.sv
// Arbiter for the single-port data bank: the CPU has fixed priority, and a starvation counter forces a bounded engine window.
// Optional feature BANK_PARAM_LOCK_EN blocks CPU writes to the parameter region while the engine is busy and flags param_err.
module bank_port_arbiter #(
  parameter int Amba_Word       = 16,
  parameter int Amba_Addr_Depth = 20,
  parameter int MAX_WAIT        = 8,
  parameter int ENG_HOLD        = 4,
  parameter int PARAM_END       = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [Amba_Addr_Depth:0] cpu_addr,
  input  logic [Amba_Word-1:0]     cpu_wdata,
  output logic                     cpu_gnt,
  output logic                     cpu_rvalid,
  output logic [Amba_Word-1:0]     cpu_rdata,
  input  logic                     eng_req,
  input  logic [Amba_Addr_Depth:0] eng_addr,
  output logic                     eng_gnt,
  output logic                     eng_rvalid,
  output logic [Amba_Word-1:0]     eng_rdata,
  input  logic                     eng_busy,
  output logic                     bank_we,
  output logic [Amba_Addr_Depth:0] bank_addr,
  output logic [Amba_Word-1:0]     bank_wdata,
  input  logic [Amba_Word-1:0]     bank_rdata
`ifdef BANK_PARAM_LOCK_EN
  ,
  output logic                     param_err
`endif
);

  localparam int ADDR_W = Amba_Addr_Depth + 1;
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);
  localparam logic [7:0] HOLD_INIT = 8'(ENG_HOLD);

  typedef enum logic {
    ARB_CPU_PRI,
    ARB_ENG_FORCE
  } arb_state_t;

  arb_state_t state, state_next;
  logic [7:0] wait_cnt, wait_next;
  logic [7:0] hold_cnt, hold_next;
  logic       cpu_tag1, cpu_tag2;
  logic       eng_tag1, eng_tag2;
  logic       lock_hit;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    state_next = state;
    wait_next  = wait_cnt;
    hold_next  = hold_cnt;
    cpu_gnt    = 1'b0;
    eng_gnt    = 1'b0;
    unique case (state)
      ARB_CPU_PRI: begin
        cpu_gnt = cpu_req;
        eng_gnt = eng_req && !cpu_req;
        if (eng_req && !eng_gnt) begin
          // The MAX_WAIT-th consecutive denial enters the forced window next cycle.
          if (wait_cnt >= WAIT_LAST) begin
            state_next = ARB_ENG_FORCE;
            hold_next  = HOLD_INIT;
            wait_next  = '0;
          end else begin
            wait_next = wait_cnt + 8'd1;
          end
        end else begin
          wait_next = '0;
        end
      end
      ARB_ENG_FORCE: begin
        eng_gnt   = eng_req;
        cpu_gnt   = cpu_req && !eng_req;
        wait_next = '0;
        if (eng_req) begin
          hold_next = hold_cnt - 8'd1;
          if (hold_cnt == 8'd1) state_next = ARB_CPU_PRI;
        end else begin
          state_next = ARB_CPU_PRI;
        end
      end
      default: state_next = ARB_CPU_PRI;
    endcase
  end

`ifdef BANK_PARAM_LOCK_EN
  assign lock_hit = cpu_gnt && cpu_we && eng_busy && (cpu_addr < ADDR_W'(PARAM_END));
`else
  logic unused_eng_busy;
  assign unused_eng_busy = eng_busy;
  assign lock_hit        = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ARB_CPU_PRI;
      wait_cnt   <= '0;
      hold_cnt   <= '0;
      bank_we    <= 1'b0;
      bank_addr  <= '0;
      bank_wdata <= '0;
      cpu_tag1   <= 1'b0;
      cpu_tag2   <= 1'b0;
      eng_tag1   <= 1'b0;
      eng_tag2   <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
      hold_cnt <= hold_next;
      bank_we  <= cpu_gnt && cpu_we && !lock_hit;
      if (cpu_gnt) begin
        bank_addr  <= cpu_addr;
        bank_wdata <= cpu_wdata;
      end else if (eng_gnt) begin
        bank_addr <= eng_addr;
      end
      // Two-stage tags line up with the one-cycle bank read behind the registered address.
      cpu_tag1 <= cpu_gnt && !cpu_we;
      eng_tag1 <= eng_gnt;
      cpu_tag2 <= cpu_tag1;
      eng_tag2 <= eng_tag1;
    end
  end

`ifdef BANK_PARAM_LOCK_EN
  always_ff @(posedge clk) begin
    if (!rst)          param_err <= 1'b0;
    else if (lock_hit) param_err <= 1'b1;
  end
`endif

  assign cpu_rvalid = cpu_tag2;
  assign eng_rvalid = eng_tag2;
  assign cpu_rdata  = bank_rdata;
  assign eng_rdata  = bank_rdata;

endmodule

// File: tb/tb_bank_port_arbiter.sv
// Scoreboard bench for bank_port_arbiter: a policy-level arbitration and memory model predicts grants, bank commands and read data.
// Define BANK_PARAM_LOCK_EN for both the bench and the RTL to cover the parameter-lock feature.
module tb_bank_port_arbiter;

  localparam int W         = 16;
  localparam int AD        = 20;
  localparam int AW        = AD + 1;
  localparam int MAX_WAIT  = 8;
  localparam int ENG_HOLD  = 4;
  localparam int PARAM_END = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [W-1:0]  cpu_wdata, cpu_rdata;
  logic          eng_req, eng_gnt, eng_rvalid, eng_busy;
  logic [AW-1:0] eng_addr;
  logic [W-1:0]  eng_rdata;
  logic          bank_we;
  logic [AW-1:0] bank_addr;
  logic [W-1:0]  bank_wdata, bank_rdata;
`ifdef BANK_PARAM_LOCK_EN
  logic          param_err;
`endif

  bank_port_arbiter #(
    .Amba_Word(W), .Amba_Addr_Depth(AD), .MAX_WAIT(MAX_WAIT),
    .ENG_HOLD(ENG_HOLD), .PARAM_END(PARAM_END)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .eng_req(eng_req), .eng_addr(eng_addr), .eng_gnt(eng_gnt),
    .eng_rvalid(eng_rvalid), .eng_rdata(eng_rdata), .eng_busy(eng_busy),
    .bank_we(bank_we), .bank_addr(bank_addr), .bank_wdata(bank_wdata),
    .bank_rdata(bank_rdata)
`ifdef BANK_PARAM_LOCK_EN
    , .param_err(param_err)
`endif
  );

  always #5 clk = ~clk;

  // Bank stand-in: registered read of the address presented in the previous cycle.
  logic [W-1:0] bank_mem [64];
  always @(posedge clk) begin
    if (bank_we) bank_mem[bank_addr[5:0]] <= bank_wdata;
    bank_rdata <= bank_mem[bank_addr[5:0]];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [W-1:0]  ref_mem [64];
  logic [W-1:0]  cpu_q[$];
  logic [W-1:0]  eng_q[$];
  int            denied, force_left;
  logic          exp_we, exp_perr;
  logic [AW-1:0] exp_addr;
  logic [W-1:0]  exp_wdata;

  task automatic model_reset();
    denied = 0; force_left = 0;
    exp_we = 1'b0; exp_addr = '0; exp_wdata = '0; exp_perr = 1'b0;
  endtask

  // One bus cycle: drive, check DUT against model at negedge, advance model.
  task automatic step(input logic creq, input logic cwe, input logic [AW-1:0] caddr,
                      input logic [W-1:0] cwd, input logic ereq, input logic [AW-1:0] eaddr,
                      input logic busy, output logic act_c, output logic act_e);
    logic mc, me, locked;
    cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
    eng_req = ereq; eng_addr = eaddr; eng_busy = busy;
    @(negedge clk);
    if (force_left > 0) begin
      me = ereq; mc = creq && !ereq;
    end else begin
      mc = creq; me = ereq && !creq;
    end
    check("cpu_gnt", {31'b0, cpu_gnt}, {31'b0, mc});
    check("eng_gnt", {31'b0, eng_gnt}, {31'b0, me});
    check("bank_we", {31'b0, bank_we}, {31'b0, exp_we});
    check("bank_addr", 32'(bank_addr), 32'(exp_addr));
    if (exp_we) check("bank_wdata", 32'(bank_wdata), 32'(exp_wdata));
`ifdef BANK_PARAM_LOCK_EN
    check("param_err", {31'b0, param_err}, {31'b0, exp_perr});
    locked = mc && cwe && busy && (int'(caddr) < PARAM_END);
`else
    locked = 1'b0;
`endif
    act_c = cpu_gnt; act_e = eng_gnt;
    exp_we = 1'b0;
    if (mc) begin
      exp_addr = caddr;
      if (cwe && !locked) begin
        exp_we = 1'b1; exp_wdata = cwd;
        ref_mem[caddr[5:0]] = cwd;
      end
      if (locked) exp_perr = 1'b1;
      if (!cwe) cpu_q.push_back(ref_mem[caddr[5:0]]);
    end else if (me) begin
      exp_addr = eaddr;
      eng_q.push_back(ref_mem[eaddr[5:0]]);
    end
    // Starvation policy: MAX_WAIT straight denials buy ENG_HOLD engine grants.
    if (force_left > 0) begin
      denied = 0;
      if (me) force_left--;
      else if (!ereq) force_left = 0;
    end else if (ereq && !me) begin
      denied++;
      if (denied == MAX_WAIT) begin
        force_left = ENG_HOLD; denied = 0;
      end
    end else begin
      denied = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    cpu_req = 1'b0; eng_req = 1'b0; eng_busy = 1'b0;
    rst = 1'b0;
    cpu_q.delete(); eng_q.delete();
    repeat (n) @(posedge clk);
    #1;
    check("rst_bank_we", {31'b0, bank_we}, 32'd0);
    check("rst_bank_addr", 32'(bank_addr), 32'd0);
    check("rst_rvalid", {30'b0, cpu_rvalid, eng_rvalid}, 32'd0);
    rst = 1'b1;
    model_reset();
  endtask

  // Monitor: pops an expectation whenever the DUT presents read data.
  always @(negedge clk) begin
    if (cpu_rvalid) begin
      if (cpu_q.size() == 0) check("cpu_rvalid_unexpected", 32'd1, 32'd0);
      else check("cpu_rdata", 32'(cpu_rdata), 32'(cpu_q.pop_front()));
    end
    if (eng_rvalid) begin
      if (eng_q.size() == 0) check("eng_rvalid_unexpected", 32'd1, 32'd0);
      else check("eng_rdata", 32'(eng_rdata), 32'(eng_q.pop_front()));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          gc, ge;
    logic          c_pend, c_we, e_req, busy;
    logic [AW-1:0] c_addr, e_addr;
    logic [W-1:0]  c_data;
    logic          pat_c [13];
    logic          pat_e [13];

    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    eng_req = 0; eng_addr = '0; eng_busy = 0; rst = 0;
    @(posedge clk); #1;
    do_reset(3);

    // Preload every bank word through the CPU port.
    for (int i = 0; i < 64; i++)
      step(1, 1, AW'(i), W'($urandom), 0, '0, 0, gc, ge);

    // CPU write then read of 0x0A.
    step(1, 1, AW'(10), 16'h00FF, 0, '0, 0, gc, ge);
    step(1, 0, AW'(10), '0, 0, '0, 0, gc, ge);
    check("wr_bank_we_seen", {31'b0, exp_we}, 32'd0);
    step(0, 0, '0, '0, 0, '0, 0, gc, ge);
    check("rd_rvalid_2cyc", {31'b0, cpu_rvalid}, 32'd1);
    check("rd_data_00ff", 32'(cpu_rdata), 32'h00FF);
    step(0, 0, '0, '0, 0, '0, 0, gc, ge);

    // Both requesters held: 8 CPU grants, 4 forced engine grants, CPU again.
    for (int i = 0; i < 13; i++) begin
      step(1, 0, AW'(i), '0, 1, AW'(20 + i), 0, gc, ge);
      pat_c[i] = gc; pat_e[i] = ge;
    end
    for (int i = 0; i < 13; i++) begin
      check("hold_pattern_cpu", {31'b0, pat_c[i]}, (i < 8 || i == 12) ? 32'd1 : 32'd0);
      check("hold_pattern_eng", {31'b0, pat_e[i]}, (i >= 8 && i < 12) ? 32'd1 : 32'd0);
    end
    step(0, 0, '0, '0, 0, '0, 0, gc, ge);

    // Engine stream alone over 0x0A..0x13.
    for (int i = 0; i < 10; i++) begin
      step(0, 0, '0, '0, 1, AW'(10 + i), 0, gc, ge);
      check("stream_eng_gnt", {31'b0, ge}, 32'd1);
    end
    repeat (3) step(0, 0, '0, '0, 0, '0, 0, gc, ge);

    // Forced window exit after one engine grant.
    for (int i = 0; i < 8; i++) step(1, 0, AW'(i), '0, 1, AW'(30), 0, gc, ge);
    step(1, 0, AW'(1), '0, 1, AW'(31), 0, gc, ge);
    check("exit_forced_eng", {31'b0, ge}, 32'd1);
    step(1, 0, AW'(2), '0, 0, '0, 0, gc, ge);
    check("exit_cpu_gnt", {31'b0, gc}, 32'd1);
    step(1, 0, AW'(3), '0, 1, AW'(32), 0, gc, ge);
    check("exit_cpu_pri", {30'b0, gc, ge}, 32'd2);
    repeat (3) step(0, 0, '0, '0, 0, '0, 0, gc, ge);

`ifdef BANK_PARAM_LOCK_EN
    // Locked parameter write is granted but never reaches the bank.
    step(1, 1, AW'(3), 16'h0020, 0, '0, 1, gc, ge);
    check("lock_gnt", {31'b0, gc}, 32'd1);
    step(1, 0, AW'(3), '0, 0, '0, 1, gc, ge);
    check("lock_we_low", {31'b0, bank_we}, 32'd0);
    check("lock_perr", {31'b0, param_err}, 32'd1);
    repeat (3) step(0, 0, '0, '0, 0, '0, 0, gc, ge);
`endif

    // Reset while an engine read is in flight.
    step(0, 0, '0, '0, 1, AW'(12), 0, gc, ge);
    do_reset(2);
    repeat (4) step(0, 0, '0, '0, 0, '0, 0, gc, ge);

    // Randomized traffic with CPU requests held until granted.
    c_pend = 0; c_we = 0; c_addr = '0; c_data = '0;
    for (int n = 0; n < 2000; n++) begin
      if (!c_pend && $urandom_range(0, 2) == 0) begin
        c_pend = 1;
        c_we   = 1'($urandom_range(0, 1));
        c_addr = AW'($urandom_range(0, 63));
        c_data = W'($urandom);
      end
      e_req  = ($urandom_range(0, 9) < 7);
      e_addr = AW'($urandom_range(0, 63));
      busy   = 1'($urandom_range(0, 1));
      step(c_pend, c_we, c_addr, c_data, e_req, e_addr, busy, gc, ge);
      if (gc) c_pend = 0;
    end
    repeat (4) step(0, 0, '0, '0, 0, '0, 0, gc, ge);
    check("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
    check("eng_q_drained", 32'(eng_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bank_port_arbiter.md
Name: bank_port_arbiter

Overview:
Arbitrates the single-port APB data bank between two requesters: the CPU-side APB slave logic and the watermark block-fetch engine.
- CPU has fixed priority.
- A starvation counter forces a bounded engine-priority window so block fetch always makes progress.
- Sits between the APB front end / fetch engine and the data bank instance.
- Issues one registered bank access per cycle and returns read data to the requester that issued it.

Parameters:
Amba_Word, 16, data width of bank words
Amba_Addr_Depth, 20, bank address MSB index (address width Amba_Addr_Depth+1)
MAX_WAIT, 8, consecutive denied engine cycles before forced engine priority (range 1..255)
ENG_HOLD, 4, engine grants guaranteed once forced priority is entered (range 1..255)
PARAM_END, 10, first non-parameter address (parameter region is 0x00..PARAM_END-1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-low reset
cpu_req  in  1  CPU access request, held until cpu_gnt
cpu_we  in  1  1=write, 0=read
cpu_addr  in  Amba_Addr_Depth+1  CPU address
cpu_wdata  in  Amba_Word  CPU write data
cpu_gnt  out  1  combinational grant; request accepted this cycle
cpu_rvalid  out  1  cpu_rdata valid this cycle
cpu_rdata  out  Amba_Word  read data to CPU
eng_req  in  1  engine read request (engine never writes)
eng_addr  in  Amba_Addr_Depth+1  engine address
eng_gnt  out  1  combinational grant to engine
eng_rvalid  out  1  eng_rdata valid this cycle
eng_rdata  out  Amba_Word  read data to engine
eng_busy  in  1  engine processing active (start && !Image_Done)
bank_we  out  1  registered bank write enable
bank_addr  out  Amba_Addr_Depth+1  registered bank address
bank_wdata  out  Amba_Word  registered bank write data
bank_rdata  in  Amba_Word  bank read data, valid one cycle after bank_addr

Behaviour:
- Reset (rst==0 at posedge): state=ARB_CPU_PRI; wait_cnt=0; hold_cnt=0; bank_we=0; bank_addr=0; bank_wdata=0; both rvalid pipeline tags cleared; param_err=0.
- Reset mid-operation: in-flight reads are discarded; no rvalid is asserted after reset for them.
- Grants are combinational from state and requests. At most one grant per cycle.
- Accepted request at edge N drives bank_we/addr/wdata at cycle N+1.
- If no grant, bank_we=0; bank_addr and bank_wdata hold their previous values.
- Read latency: grant in cycle N gives rvalid in cycle N+2. rdata = bank_rdata (pass-through) and is meaningful only while rvalid is high.
- Writes produce no rvalid.
- Back-to-back grants are allowed every cycle; the rvalid pipeline depth is 2.
- State ARB_CPU_PRI:
  - cpu_req -> cpu_gnt. Otherwise eng_req -> eng_gnt.
  - wait_cnt: +1 while eng_req && !eng_gnt; cleared on eng_gnt or !eng_req; saturates at MAX_WAIT.
  - wait_cnt reaching MAX_WAIT -> ARB_ENG_FORCE next cycle, with hold_cnt=ENG_HOLD and wait_cnt=0.
- State ARB_ENG_FORCE:
  - eng_req -> eng_gnt and hold_cnt-1. Otherwise cpu_req -> cpu_gnt.
  - Return to ARB_CPU_PRI when a grant makes hold_cnt 0, or when eng_req is low for a cycle.
- Both requesters idle: no grant, no state change, counters unchanged except wait_cnt clear.
- Simultaneous requests: CPU wins in ARB_CPU_PRI; engine wins in ARB_ENG_FORCE.
- eng_busy is used only by the optional feature.

Optional Feature:
Macro BANK_PARAM_LOCK_EN.
- Defined:
  - CPU write with cpu_addr < PARAM_END while eng_busy=1 is still granted (cpu_gnt=1) but issued with bank_we=0; the bank is not modified.
  - Extra output param_err (1 bit) sets sticky on such a write and is cleared only by reset.
  - CPU reads are unaffected.
- Undefined: no param_err port; all granted CPU writes reach the bank unchanged.

Test Plan:
- CPU write then read: write addr 0x0A data 0x00FF, then read 0x0A -> bank_we=1 one cycle after grant; cpu_rvalid=1 with cpu_rdata=0x00FF two cycles after read grant; eng_rvalid stays 0.
- Simultaneous requests, MAX_WAIT=8: cpu_req and eng_req both held high continuously -> cpu_gnt for cycles 0..7; forced window gives eng_gnt for exactly 4 cycles; cpu_gnt resumes after that.
- Engine stream alone: eng_req high, addresses 0x0A..0x13 -> eng_gnt every cycle; 10 eng_rvalid pulses in address order starting 2 cycles after the first grant.
- Forced window exit: after forced entry, eng_req drops after 1 grant -> return to ARB_CPU_PRI; pending cpu_req granted the next cycle.
- Reset mid-read: engine read granted, rst low the next cycle -> no eng_rvalid; bank_we=0 and bank_addr=0 after reset.
- BANK_PARAM_LOCK_EN: eng_busy=1, CPU write addr 0x03 data 0x0020 -> cpu_gnt=1, bank_we=0, param_err=1; read 0x03 returns the old value.
